signed_addsub_seq: RTL and testbench

//  Parametrised multi-cycle two's-complement adder/subtractor for the sign calculator datapath.

---
 rtl/signed_addsub_seq.sv | 144 ++++++++++++++
 tb/tb_signed_addsub_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/signed_addsub_seq.sv
// Multi-cycle two's-complement adder/subtractor: CHUNK bits per cycle, LSB chunk first,
// with valid/ready handshakes and sign/zero/overflow/carry/magnitude flags.
module signed_addsub_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] mag,
    output logic             carry,
    output logic             ovf,
    output logic             neg,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int BW     = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    generate
        if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
            $error("signed_addsub_seq: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_op;
    logic             r_cy;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [BW-1:0]    w_base;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_sum;
    logic             w_cin_msb;
    logic             w_ovf;

    // Two's-complement magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1) as unsigned.
    function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    assign w_base    = BW'(r_cnt) * BW'(CHUNK);
    assign w_a_chunk = r_a[w_base +: CHUNK];
    assign w_b_chunk = r_op ? ~r_b[w_base +: CHUNK] : r_b[w_base +: CHUNK];
    assign w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_cy};
    // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
    assign w_cin_msb = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_sum[CHUNK-1];
    assign w_ovf     = w_cin_msb ^ w_sum[CHUNK];

    // Control FSM and chunked ripple datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_op        <= 1'b0;
            r_cy        <= 1'b0;
            r_cnt       <= {CW{1'b0}};
            r_result    <= {WIDTH{1'b0}};
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_op       <= op;
                        r_cy       <= op;
                        r_cnt      <= {CW{1'b0}};
                        r_result   <= {WIDTH{1'b0}};
                        r_carry    <= 1'b0;
                        r_ovf      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_result[w_base +: CHUNK] <= w_sum[CHUNK-1:0];
                    r_cy                      <= w_sum[CHUNK];
                    if (r_cnt == LAST_CNT) begin
                        r_carry     <= r_op ^ w_sum[CHUNK];
                        r_ovf       <= w_ovf;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign carry     = r_carry;
    assign ovf       = r_ovf;
    assign neg       = r_result[WIDTH-1];
    assign zero      = (r_result == {WIDTH{1'b0}});
    assign mag       = abs_mag(r_result);

endmodule

// File: tb/tb_signed_addsub_seq.sv
// Randomised and directed bench for signed_addsub_seq in the 8/4 and 16/1 configurations,
// checked against an integer-arithmetic reference model.
module tb_signed_addsub_seq;

    logic        clk;
    logic        rst;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        iv8, or8, iv16, or16;

    logic        ir8, ov8, cy8, ovf8, neg8, zero8;
    logic [7:0]  res8, mag8;
    logic        ir16, ov16, cy16, ovf16, neg16, zero16;
    logic [15:0] res16, mag16;

    logic        sel;
    logic        o_ir, o_ov, o_cy, o_ovf, o_neg, o_zero;
    logic [15:0] o_res, o_mag;

    int n_checks = 0;
    int n_fail   = 0;

    signed_addsub_seq #(.WIDTH(8), .CHUNK(4)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .op(op),
        .a(a[7:0]), .b(b[7:0]), .out_valid(ov8), .out_ready(or8),
        .result(res8), .mag(mag8), .carry(cy8), .ovf(ovf8), .neg(neg8), .zero(zero8)
    );

    signed_addsub_seq #(.WIDTH(16), .CHUNK(1)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .op(op),
        .a(a), .b(b), .out_valid(ov16), .out_ready(or16),
        .result(res16), .mag(mag16), .carry(cy16), .ovf(ovf16), .neg(neg16), .zero(zero16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        o_ir   = sel ? ir16   : ir8;
        o_ov   = sel ? ov16   : ov8;
        o_cy   = sel ? cy16   : cy8;
        o_ovf  = sel ? ovf16  : ovf8;
        o_neg  = sel ? neg16  : neg8;
        o_zero = sel ? zero16 : zero8;
        o_res  = sel ? res16  : {8'h00, res8};
        o_mag  = sel ? mag16  : {8'h00, mag8};
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_iv(input logic s, input logic v);
        if (s) iv16 = v; else iv8 = v;
    endtask

    task automatic set_or(input logic s, input logic v);
        if (s) or16 = v; else or8 = v;
    endtask

    task automatic run_op(input logic s, input logic o, input logic [15:0] av,
                          input logic [15:0] bv, input int hold);
        int    w;
        int    lat;
        int    n;
        longint mask, ua, ub, r, sa, sb, sr;
        logic [15:0] e_res, e_mag;
        logic  e_cy, e_ovf, e_neg;
        w    = s ? 16 : 8;
        lat  = s ? 16 : 2;
        mask = (64'sd1 <<< w) - 1;
        ua   = longint'(av) & mask;
        ub   = longint'(bv) & mask;
        if (o) begin
            r    = (ua - ub) & mask;
            e_cy = (ua < ub);
        end else begin
            r    = (ua + ub) & mask;
            e_cy = (((ua + ub) >>> w) & 1) != 0;
        end
        sa    = (ua >>> (w - 1)) & 1;
        sb    = (ub >>> (w - 1)) & 1;
        sr    = (r  >>> (w - 1)) & 1;
        e_ovf = o ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        e_neg = (sr != 0);
        e_res = 16'(r);
        e_mag = e_neg ? 16'(((64'sd1 <<< w) - r) & mask) : 16'(r);

        sel = s;
        check_val("in_ready_idle", {31'd0, o_ir}, 32'd1);
        op = o; a = av; b = bv;
        set_iv(s, 1'b1);
        @(posedge clk); #1;
        set_iv(s, 1'b0);
        n = 0;
        while (!o_ov && n < 40) begin
            a = 16'($urandom); b = 16'($urandom); op = 1'($urandom);
            set_iv(s, 1'($urandom));
            @(posedge clk); #1;
            n++;
        end
        set_iv(s, 1'b0);
        check_val("latency", 32'(n), 32'(lat));
        check_val("result", {16'd0, o_res}, {16'd0, e_res});
        check_val("carry",  {31'd0, o_cy},  {31'd0, e_cy});
        check_val("ovf",    {31'd0, o_ovf}, {31'd0, e_ovf});
        check_val("neg",    {31'd0, o_neg}, {31'd0, e_neg});
        check_val("zero",   {31'd0, o_zero}, {31'd0, (r == 0)});
        check_val("mag",    {16'd0, o_mag}, {16'd0, e_mag});
        for (int i = 0; i < hold; i++) begin
            a = 16'($urandom); b = 16'($urandom); op = 1'($urandom);
            set_iv(s, 1'($urandom));
            @(posedge clk); #1;
            check_val("hold_valid",  {31'd0, o_ov}, 32'd1);
            check_val("hold_ready",  {31'd0, o_ir}, 32'd0);
            check_val("hold_result", {16'd0, o_res}, {16'd0, e_res});
            check_val("hold_ovf",    {31'd0, o_ovf}, {31'd0, e_ovf});
        end
        set_iv(s, 1'b0);
        set_or(s, 1'b1);
        @(posedge clk); #1;
        set_or(s, 1'b0);
        check_val("valid_drop",   {31'd0, o_ov}, 32'd0);
        check_val("ready_return", {31'd0, o_ir}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; op = 1'b0; a = 16'h0000; b = 16'h0000;
        iv8 = 1'b0; or8 = 1'b0; iv16 = 1'b0; or16 = 1'b0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            #0;
            check_val("rst_out_valid", {31'd0, o_ov}, 32'd0);
            check_val("rst_in_ready",  {31'd0, o_ir}, 32'd1);
            check_val("rst_result",    {16'd0, o_res}, 32'd0);
            check_val("rst_zero",      {31'd0, o_zero}, 32'd1);
            check_val("rst_mag",       {16'd0, o_mag}, 32'd0);
            check_val("rst_neg",       {31'd0, o_neg}, 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(1'b0, 1'b0, 16'h0064, 16'h001B, 0);
        run_op(1'b0, 1'b1, 16'h0064, 16'h00E4, 0);
        run_op(1'b0, 1'b1, 16'h0005, 16'h0005, 0);
        run_op(1'b0, 1'b1, 16'h0003, 16'h0007, 0);
        run_op(1'b0, 1'b0, 16'h007F, 16'h0001, 10);
        run_op(1'b0, 1'b0, 16'h0080, 16'h0080, 1);
        out_ready_idle_check: begin
            or8 = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            or8 = 1'b0;
            sel = 1'b0;
            check_val("idle_out_ready_valid", {31'd0, o_ov}, 32'd0);
            check_val("idle_out_ready_ready", {31'd0, o_ir}, 32'd1);
        end
        for (int i = 0; i < 40; i++) begin
            run_op(1'b0, 1'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
        end

        // Abort after the first CALC cycle.
        sel = 1'b0;
        op = 1'b0; a = 16'h0011; b = 16'h0022;
        iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_val("abort_out_valid", {31'd0, o_ov}, 32'd0);
        check_val("abort_result",    {16'd0, o_res}, 32'd0);
        check_val("abort_zero",      {31'd0, o_zero}, 32'd1);
        check_val("abort_in_ready",  {31'd0, o_ir}, 32'd1);
        #2;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(1'b1, 1'b0, 16'h7FFF, 16'h0001, 2);
        run_op(1'b1, 1'b1, 16'h8000, 16'h0001, 0);
        run_op(1'b1, 1'b1, 16'h1234, 16'h1234, 0);
        for (int i = 0; i < 8; i++) begin
            run_op(1'b1, 1'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
